// File: rtl/counter_wrap_extender.sv
// Tracks a 3-bit up/down counter, extends it with an EXT_W-bit wrap count and flags illegal steps.
// Optional macro WRAP_SATURATE_EN: the extension field saturates instead of wrapping.
module counter_wrap_extender #(
    parameter int EXT_W = 5
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic [2:0]       q_in,
    input  logic             load_in,
    input  logic             up_down_in,
    input  logic             err_clr_in,
    output logic [EXT_W+2:0] wide_out,
    output logic             wrap_up_out,
    output logic             wrap_dn_out,
    output logic             err_out
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         prev_q, prev_d;
    logic [EXT_W-1:0]   ext_q, ext_d;
    logic               ld_q, ld_d;
    logic               dir_q, dir_d;
    logic               wrap_up_q, wrap_up_d;
    logic               wrap_dn_q, wrap_dn_d;

    logic [2:0]         delta;
    logic [EXT_W-1:0]   ext_inc;
    logic [EXT_W-1:0]   ext_dec;

    assign delta = q_in - prev_q;

`ifdef WRAP_SATURATE_EN
    assign ext_inc = (&ext_q)         ? ext_q : ext_q + 1'b1;
    assign ext_dec = (ext_q == '0)    ? ext_q : ext_q - 1'b1;
`else
    assign ext_inc = ext_q + 1'b1;
    assign ext_dec = ext_q - 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        ext_d     = ext_q;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        // Controls are delayed one cycle so each sampled step is judged by the controls that caused it.
        ld_d      = load_in;
        dir_d     = up_down_in;

        case (state_q)
            ST_INIT: begin
                prev_d  = q_in;
                state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (ld_q) begin
                    ext_d  = '0;
                    prev_d = q_in;
                end else if (delta == 3'd1 && dir_q) begin
                    prev_d = q_in;
                    if (prev_q == 3'd7) begin
                        ext_d     = ext_inc;
                        wrap_up_d = 1'b1;
                    end
                end else if (delta == 3'd7 && !dir_q) begin
                    prev_d = q_in;
                    if (prev_q == 3'd0) begin
                        ext_d     = ext_dec;
                        wrap_dn_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (err_clr_in) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_INIT;
            prev_q    <= '0;
            ext_q     <= '0;
            ld_q      <= 1'b0;
            dir_q     <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            ext_q     <= ext_d;
            ld_q      <= ld_d;
            dir_q     <= dir_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
        end
    end

    assign wide_out    = {ext_q, prev_q};
    assign wrap_up_out = wrap_up_q;
    assign wrap_dn_out = wrap_dn_q;
    assign err_out     = (state_q == ST_ERROR);

endmodule
